// File: rtl/contador_bcd_cascata_pkg.sv
// Shared types and constants for the cascaded BCD counter.
// FIM is only reachable when CONTADOR_SATURA_EN is defined.
package contador_bcd_cascata_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    FIM      = 2'd2
  } estado_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/contador_bcd_cascata_digito.sv
// One BCD decade with ripple carry/borrow out.
// Parallel load has priority over stepping.
module digito_bcd
  import contador_bcd_cascata_pkg::*;
(
  input  logic       novo_clock,
  input  logic       reset,
  input  logic       en_i,
  input  logic       up_down_i,
  input  logic       load_i,
  input  logic [3:0] load_digit_i,
  output logic [3:0] digit_o,
  output logic       cout_o
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_digit_i;
    end else if (en_i) begin
      if (up_down_i)
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge novo_clock or posedge reset) begin
    if (reset) digit_q <= BCD_MIN;
    else       digit_q <= digit_d;
  end

  assign digit_o = digit_q;
  assign cout_o  = en_i & (up_down_i ? (digit_q == BCD_MAX)
                                     : (digit_q == BCD_MIN));

endmodule

// File: rtl/contador_bcd_cascata.sv
// N-digit BCD up/down counter with start/stop FSM and flags.
// Define CONTADOR_SATURA_EN to saturate into FIM instead of wrapping.
module contador_bcd_cascata
  import contador_bcd_cascata_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  novo_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_value,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  running,
  output logic                  tc,
  output logic                  overflow
);

  estado_e state_q, state_d;
  logic    overflow_q, overflow_d;
  logic    step;
  logic    all_term;

  logic [N_DIGITS:0]   carry;
  logic [N_DIGITS-1:0] term;

  assign carry[0] = step;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
    digito_bcd u_dig (
      .novo_clock  (novo_clock),
      .reset       (reset),
      .en_i        (carry[i]),
      .up_down_i   (up_down),
      .load_i      (load),
      .load_digit_i(bcd_sat(load_value[4*i +: 4])),
      .digit_o     (count[4*i +: 4]),
      .cout_o      (carry[i+1])
    );
    assign term[i] = up_down ? (count[4*i +: 4] == BCD_MAX)
                             : (count[4*i +: 4] == BCD_MIN);
  end

  assign all_term = &term;

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    step       = 1'b0;
    if (load) begin
      state_d    = PARADO;
      overflow_d = 1'b0;
    end else if (stop) begin
      state_d = PARADO;
    end else if (start && state_q != CONTANDO) begin
      state_d = CONTANDO;
    end else if (state_q == CONTANDO) begin
`ifdef CONTADOR_SATURA_EN
      if (all_term) begin
        state_d    = FIM;
        overflow_d = 1'b1;
      end else begin
        step = 1'b1;
      end
`else
      step = 1'b1;
      // carry out of the top decade means the whole chain wrapped
      if (carry[N_DIGITS]) overflow_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge novo_clock or posedge reset) begin
    if (reset) begin
      state_q    <= PARADO;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign running  = (state_q == CONTANDO);
  assign tc       = running & all_term;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_contador_bcd_cascata.sv
// Directed self-checking bench for contador_bcd_cascata.
// Expectations follow CONTADOR_SATURA_EN when it is defined.
module tb_contador_bcd_cascata;

  logic        novo_clock = 1'b0;
  logic        reset, start, stop, up_down, load;
  logic [15:0] load_value;
  logic [15:0] count;
  logic        running, tc, overflow;

  int checks = 0;
  int errors = 0;

  contador_bcd_cascata #(.N_DIGITS(4)) dut (
    .novo_clock(novo_clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .up_down   (up_down),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .running   (running),
    .tc        (tc),
    .overflow  (overflow)
  );

  always #5 novo_clock = ~novo_clock;

  task automatic tick();
    @(posedge novo_clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    up_down = 1'b1;
    load = 1'b0;
    load_value = 16'h0;
    #3;
    chk("rst_count", count, 16'h0000);
    chk("rst_running", running, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_tc", tc, 1'b0);
    reset = 1'b0;

    // 1: up across decade boundaries
    do_load(16'h0098);
    chk("t1_load", count, 16'h0098);
    chk("t1_idle", running, 1'b0);
    up_down = 1'b1;
    do_start();
    chk("t1_start_run", running, 1'b1);
    chk("t1_start_hold", count, 16'h0098);
    tick();
    chk("t1_s1", count, 16'h0099);
    tick();
    chk("t1_s2", count, 16'h0100);
    tick();
    chk("t1_s3", count, 16'h0101);
    chk("t1_ovf", overflow, 1'b0);

    // 2: up wrap / saturate
    do_load(16'h9998);
    do_start();
    tick();
    chk("t2_9999", count, 16'h9999);
    chk("t2_tc", tc, 1'b1);
    tick();
    chk("t2_ovf", overflow, 1'b1);
`ifdef CONTADOR_SATURA_EN
    chk("t2_hold", count, 16'h9999);
    chk("t2_run", running, 1'b0);
`else
    chk("t2_wrap", count, 16'h0000);
    chk("t2_run", running, 1'b1);
`endif
    chk("t2_tc_after", tc, 1'b0);

    // 3: down wrap / saturate
    do_load(16'h0001);
    chk("t3_ovf_clr", overflow, 1'b0);
    up_down = 1'b0;
    do_start();
    tick();
    chk("t3_zero", count, 16'h0000);
    chk("t3_tc", tc, 1'b1);
    tick();
    chk("t3_ovf", overflow, 1'b1);
`ifdef CONTADOR_SATURA_EN
    chk("t3_hold", count, 16'h0000);
    chk("t3_run", running, 1'b0);
    chk("t3_tc_fim", tc, 1'b0);
    // restart in FIM without reversing saturates again
    do_start();
    chk("t3_rerun", running, 1'b1);
    tick();
    chk("t3_resat", running, 1'b0);
    chk("t3_resat_cnt", count, 16'h0000);
`else
    chk("t3_wrap", count, 16'h9999);
    chk("t3_tc_dn", tc, 1'b0);
    up_down = 1'b1;
    #1;
    chk("t3_tc_comb", tc, 1'b1);
`endif

    // 4: stop beats start; direction change mid-count
    do_load(16'h0040);
    up_down = 1'b1;
    do_start();
    tick();
    tick();
    chk("t4_0042", count, 16'h0042);
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    chk("t4_stop_run", running, 1'b0);
    chk("t4_stop_cnt", count, 16'h0042);
    tick();
    chk("t4_hold", count, 16'h0042);
    do_start();
    up_down = 1'b0;
    tick();
    chk("t4_dn", count, 16'h0041);
    up_down = 1'b1;
    tick();
    chk("t4_up", count, 16'h0042);

    // 5: asynchronous reset between edges
    do_load(16'h0500);
    do_start();
    tick();
    chk("t5_0501", count, 16'h0501);
    #2 reset = 1'b1;
    #1;
    chk("t5_cnt", count, 16'h0000);
    chk("t5_run", running, 1'b0);
    chk("t5_ovf", overflow, 1'b0);
    #1 reset = 1'b0;
    tick();
    tick();
    chk("t5_idle", count, 16'h0000);
    chk("t5_idle_run", running, 1'b0);

    // 6: load sanitising and load priority over start
    do_load(16'hA3F7);
    chk("t6_sat", count, 16'h9397);
    do_load(16'h1234);
    do_start();
    tick();
    chk("t6_1235", count, 16'h1235);
    load = 1'b1;
    start = 1'b1;
    load_value = 16'h0777;
    tick();
    load = 1'b0;
    start = 1'b0;
    chk("t6_ld_cnt", count, 16'h0777);
    chk("t6_ld_run", running, 1'b0);
    tick();
    chk("t6_ld_hold", count, 16'h0777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
